seg_display_ctrl: RTL
=====================

Name: seg_display_ctrl

Overview:
Parametrised multiplexed seven-segment display controller. It selects one of NCH 32-bit debug channels (CPU register taps) and shows it as hex on a DIGITS-digit common-anode display. It adds tear-free frame snapshots, an auto-rotate channel mode, freeze, leading-zero blanking and an enable-gated blank. It sits in the board top between the CPU debug outputs and the board display pins, and replaces the fixed 4:1 mux plus 8-digit driver pair.

Parameters:
DIGITS, 8, number of hex digits scanned (1..8); digit k shows nibble k of the snapshot.
NCH, 4, number of 32-bit input channels (2..16).
SELW, 2, width of the channel-select signals; must be at least clog2(NCH).
SCAN_DIV, 100000, clk cycles each digit is driven; minimum 1.
ROT_DIV, 50000000, clk cycles per channel in auto-rotate mode; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
en  in  1  1 = scan and display; 0 = hold all counters and blank the display
ch_data  in  NCH*32  channel c occupies bits [32c+31:32c]
ch_sel  in  SELW  manual channel select, used when auto_mode=0
auto_mode  in  1  1 = rotate through channels every ROT_DIV cycles
freeze  in  1  1 = keep the current snapshot (no frame reload)
blank_lz  in  1  1 = blank leading zero digits
o_seg  out  8  segments, active-low: bit7 = dp, bits 6..0 = g..a
o_sel  out  DIGITS  digit enables, active-low, one-hot
cur_ch  out  SELW  channel currently feeding snapshots

Behaviour:
- Reset (rst=0, async) sets the following, all held until rst rises:
  - o_seg = 8'hFF; o_sel = all ones; cur_ch = 0.
  - snapshot = 0; scan counter = 0; rotate counter = 0; digit index = 0.
- Scan counter runs 0..SCAN_DIV-1 while en=1. At its terminal count:
  - scan counter returns to 0;
  - digit index advances; DIGITS-1 wraps to 0.
- Frame boundary is the cycle the digit index wraps to 0.
  - At a frame boundary with freeze=0: snapshot <= ch_data[cur_ch], using the cur_ch value in effect before any same-cycle update.
  - freeze=1: snapshot is held; scanning continues normally.
- Channel select, manual mode (auto_mode=0):
  - cur_ch <= ch_sel one cycle later.
  - ch_sel >= NCH clamps to NCH-1.
  - Rotate counter is held at 0.
- Channel select, auto mode (auto_mode=1):
  - Rotate counter runs 0..ROT_DIV-1 while en=1.
  - At terminal count, cur_ch <= (cur_ch+1) mod NCH.
  - On a 0->1 transition of auto_mode, rotation starts from the current cur_ch with the counter at 0.
- Digit decode (hex, segment bits g..a, active-low):
  0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Decimal point: dp is lit (bit7=0) on digit 0 only when auto_mode=1; otherwise bit7=1.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked (o_seg=8'hFF, dp included) if nibbles k..DIGITS-1 of the snapshot are all zero and k>0.
  - Digit 0 is never blanked, so an all-zero snapshot shows a single "0".
- Outputs are registered. The o_sel/o_seg pair updates one cycle after the digit index changes. o_sel has bit idx low and all other bits high.
- en=0:
  - Scan and rotate counters, digit index, snapshot and cur_ch hold; manual ch_sel tracking is also paused.
  - From the next cycle: o_sel = all ones, o_seg = 8'hFF.
  - When en returns to 1, scanning resumes from the held state, with no skipped digit.
- DIGITS < 8: the upper nibbles are ignored for both display and blanking.
- Only one o_sel bit is ever low. No glitch states occur, including on the cycle after reset release.

Test Plan:
- Reset and basic scan:
  - Setup: DIGITS=8, SCAN_DIV=2, en=1, ch_sel=0, ch_data[0]=32'h12345678, blank_lz=0; release rst.
  - Required: o_sel walks FE,FD,...,7F every 2 cycles. After the first frame boundary, o_seg shows 8(80), 7(F8), ..., 1(F9) for digits 0..7.
- Manual select and clamp:
  - Setup: NCH=3, SELW=2, ch_sel=3, ch_data[2]=32'h0000ABCD.
  - Required: cur_ch=2. Next frame shows D,C,b,A (A1,C6,83,88) on digits 0..3, then 0 (C0) on digits 4..7.
- Leading-zero blank:
  - Setup: snapshot 32'h000000A0, blank_lz=1.
  - Required: digit0=C0, digit1=88, digits 2..7 = FF. With snapshot 0, digit0=C0 and all other digits = FF.
- Auto rotate:
  - Setup: NCH=4, ROT_DIV=5, auto_mode=1 from cur_ch=3.
  - Required: cur_ch goes 0 after 5 cycles, then 1 after 5 more. dp is lit on digit 0 (o_seg=40 for a "0" digit).
- Freeze and en gating:
  - Setup: freeze=1, then change ch_data; separately, drop en for 10 cycles mid-frame.
  - Required: with freeze=1, the display is unchanged across frames. While en=0, o_sel/o_seg are FF/FF. After en=1, the same digit index resumes.
- Async reset mid-frame:
  - Setup: assert rst=0 between clk edges during auto rotation.
  - Required: outputs go to their reset values immediately, without waiting for a clock edge, and cur_ch=0.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment hex display controller for 32-bit debug channels.
// Features: frame snapshots, auto-rotate, freeze, leading-zero blanking and en gating.
module seg_display_ctrl #(
  parameter int DIGITS   = 8,
  parameter int NCH      = 4,
  parameter int SELW     = 2,
  parameter int SCAN_DIV = 100000,
  parameter int ROT_DIV  = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NCH*32-1:0]   ch_data,
  input  logic [SELW-1:0]     ch_sel,
  input  logic                auto_mode,
  input  logic                freeze,
  input  logic                blank_lz,
  output logic [7:0]          o_seg,
  output logic [DIGITS-1:0]   o_sel,
  output logic [SELW-1:0]     cur_ch
);

  localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RTW  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SCW-1:0]  SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [RTW-1:0]  ROT_LAST   = RTW'(ROT_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DIGITS - 1);
  localparam logic [SELW-1:0] CH_LAST    = SELW'(NCH - 1);
  localparam logic [31:0]     DIGIT_MASK = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);

  // Hex nibble to active-low g..a segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Out-of-range manual selects land on the highest real channel.
  function automatic logic [SELW-1:0] clamp_sel(input logic [SELW-1:0] sel);
    logic [SELW-1:0] res;
    if (32'(sel) >= 32'(NCH)) begin
      res = CH_LAST;
    end else begin
      res = sel;
    end
    return res;
  endfunction

  logic [SCW-1:0]  scan_cnt_r;
  logic [RTW-1:0]  rot_cnt_r;
  logic [IDXW-1:0] idx_r;
  logic [31:0]     snap_r;
  logic [SELW-1:0] cur_ch_r;

  logic            scan_wrap_s;
  logic            frame_wrap_s;
  logic            rot_wrap_s;
  logic [31:0]     sel_data_s;
  logic [3:0]      cur_nib_s;
  logic            upper_zero_s;
  logic [7:0]      seg_s;
  logic [DIGITS-1:0] sel_s;

  assign cur_ch = cur_ch_r;

  // Terminal-count decodes for the scan and rotate dividers.
  always_comb begin
    scan_wrap_s  = (scan_cnt_r == SCAN_LAST);
    frame_wrap_s = scan_wrap_s && (idx_r == IDX_LAST);
    rot_wrap_s   = (rot_cnt_r == ROT_LAST);
  end

  // Channel mux feeding the snapshot register.
  always_comb begin
    sel_data_s = 32'h0000_0000;
    for (int c = 0; c < NCH; c++) begin
      if (cur_ch_r == SELW'(c)) begin
        sel_data_s = ch_data[32*c +: 32];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Current digit nibble and whether it and every higher shown nibble are zero.
  always_comb begin
    cur_nib_s    = 4'h0;
    upper_zero_s = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx_r == IDXW'(d)) begin
        cur_nib_s    = snap_r[4*d +: 4];
        upper_zero_s = (((snap_r & DIGIT_MASK) >> (4 * d)) == 32'h0000_0000);
      end else begin
        cur_nib_s    = cur_nib_s;
        upper_zero_s = upper_zero_s;
      end
    end
  end

  // Segment pattern and digit enable for the digit being scanned.
  always_comb begin
    seg_s = 8'hFF;
    sel_s = ~(DIGITS'(1) << idx_r);
    if (blank_lz && (idx_r != IDXW'(0)) && upper_zero_s) begin
      seg_s = 8'hFF;
    end else begin
      seg_s = {~(auto_mode && (idx_r == IDXW'(0))), hex_to_seg(cur_nib_s)};
    end
  end

  // Scan divider, digit index and frame snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_r <= '0;
      idx_r      <= '0;
      snap_r     <= 32'h0000_0000;
    end else if (en) begin
      if (scan_wrap_s) begin
        scan_cnt_r <= '0;
        if (idx_r == IDX_LAST) begin
          idx_r <= '0;
        end else begin
          idx_r <= idx_r + IDXW'(1);
        end
      end else begin
        scan_cnt_r <= scan_cnt_r + SCW'(1);
      end
      if (frame_wrap_s && !freeze) begin
        snap_r <= sel_data_s;
      end
    end
  end

  // Channel selection: manual tracking or timed rotation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_cnt_r <= '0;
      cur_ch_r  <= '0;
    end else if (en) begin
      if (auto_mode) begin
        if (rot_wrap_s) begin
          rot_cnt_r <= '0;
          if (cur_ch_r >= CH_LAST) begin
            cur_ch_r <= '0;
          end else begin
            cur_ch_r <= cur_ch_r + SELW'(1);
          end
        end else begin
          rot_cnt_r <= rot_cnt_r + RTW'(1);
        end
      end else begin
        // Held at zero so a switch into auto starts a full period from cur_ch.
        rot_cnt_r <= '0;
        cur_ch_r  <= clamp_sel(ch_sel);
      end
    end
  end

  // Registered display pins; blank whenever disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_seg <= 8'hFF;
      o_sel <= {DIGITS{1'b1}};
    end else if (en) begin
      o_seg <= seg_s;
      o_sel <= sel_s;
    end else begin
      o_seg <= 8'hFF;
      o_sel <= {DIGITS{1'b1}};
    end
  end

endmodule
